// File: rtl/rv32_barrel_mvu_jobq_if.sv
// CSR-side and MVU-side signal bundle for the per-hart MVU job queue.
interface rv32_barrel_mvu_jobq_if #(
    parameter int NUM_HARTS = 8,
    parameter int NUM_CFG   = 25,
    parameter int HART_W    = $clog2(NUM_HARTS)
);
    logic [HART_W-1:0]      hart_id_i;
    logic [11:0]            csr_addr;
    logic [31:0]            csr_wdata;
    logic [2:0]             csr_op;
    logic [31:0]            csr_rdata;
    logic                   csr_hit;
    // Job handshake: a job transfers at the clk edge where job_valid_o && job_ready_i;
    // while job_valid_o is high and job_ready_i low, job_hart_o and job_cfg_o stay stable.
    logic                   job_valid_o;
    logic                   job_ready_i;
    logic [HART_W-1:0]      job_hart_o;
    logic [32*NUM_CFG-1:0]  job_cfg_o;
    logic [NUM_HARTS-1:0]   mvu_done_i;
    logic [NUM_HARTS-1:0]   mvu_irq_o;
    logic [NUM_HARTS-1:0]   busy_o;
    logic [2*NUM_HARTS-1:0] dbg_state_o;

    modport master (
        output hart_id_i, csr_addr, csr_wdata, csr_op, job_ready_i, mvu_done_i,
        input  csr_rdata, csr_hit, job_valid_o, job_hart_o, job_cfg_o, mvu_irq_o, busy_o, dbg_state_o
    );
    modport slave (
        input  hart_id_i, csr_addr, csr_wdata, csr_op, job_ready_i, mvu_done_i,
        output csr_rdata, csr_hit, job_valid_o, job_hart_o, job_cfg_o, mvu_irq_o, busy_o, dbg_state_o
    );
endinterface

// File: rtl/rv32_barrel_mvu_jobq.sv
// Per-hart MVU config CSR bank with IDLE/PEND/RUN job lifecycle and a round-robin launcher
// onto one shared MVU job port.
module rv32_barrel_mvu_jobq #(
    parameter int          NUM_HARTS = 8,
    parameter int          NUM_CFG   = 25,
    parameter logic [11:0] CSR_BASE  = 12'hF20
) (
    input logic                   clk,
    input logic                   rst,
    rv32_barrel_mvu_jobq_if.slave bus
);
    localparam int          HART_W   = $clog2(NUM_HARTS);
    localparam logic [11:0] CMD_OFF  = 12'(NUM_CFG);
    localparam logic [11:0] STAT_OFF = 12'(NUM_CFG + 1);
    localparam logic [2:0]  OP_WRITE = 3'b001;
    localparam logic [2:0]  OP_SET   = 3'b010;
    localparam logic [2:0]  OP_CLEAR = 3'b011;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_RUN = 2'd2} hart_state_e;

    hart_state_e          r_state     [NUM_HARTS];
    hart_state_e          w_state_nxt [NUM_HARTS];
    logic [31:0]          r_cfg       [NUM_HARTS][NUM_CFG];
    logic [NUM_HARTS-1:0] r_irq_en;
    logic [NUM_HARTS-1:0] r_done;
    logic [NUM_HARTS-1:0] r_err;
    logic                 r_job_valid;
    logic [HART_W-1:0]    r_job_hart;
    logic [HART_W-1:0]    r_rr;

    logic [11:0]          w_off;
    logic                 w_hit;
    logic                 w_access;
    logic                 w_is_cmd;
    logic                 w_is_stat;
    logic                 w_start;
    logic                 w_grant;
    logic                 w_found;
    logic [HART_W-1:0]    w_pick;
    logic [31:0]          w_old;
    logic [31:0]          w_new;
    logic [NUM_HARTS-1:0] w_sel;
    logic [NUM_HARTS-1:0] w_pend;
    logic [NUM_HARTS-1:0] w_start_ok;
    logic [NUM_HARTS-1:0] w_start_err;
    logic [NUM_HARTS-1:0] w_cfg_err;

    assign w_off     = bus.csr_addr - CSR_BASE;
    assign w_hit     = (bus.csr_addr >= CSR_BASE) && (w_off <= STAT_OFF);
    assign w_access  = w_hit && (bus.csr_op inside {OP_WRITE, OP_SET, OP_CLEAR});
    assign w_is_cmd  = (w_off == CMD_OFF);
    assign w_is_stat = (w_off == STAT_OFF);
    assign w_grant   = r_job_valid && bus.job_ready_i;

    // Read mux over the current register state of the accessing hart
    always_comb begin
        w_old = '0;
        if (w_hit) begin
            if (w_is_cmd) begin
                w_old = {30'd0, r_irq_en[bus.hart_id_i], 1'b0};
            end else if (w_is_stat) begin
                w_old = {28'd0, r_err[bus.hart_id_i], r_done[bus.hart_id_i],
                         r_state[bus.hart_id_i] == S_RUN, r_state[bus.hart_id_i] == S_PEND};
            end else begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (w_off == 12'(i)) w_old = r_cfg[bus.hart_id_i][i];
                end
            end
        end
    end

    always_comb begin
        case (bus.csr_op)
            OP_WRITE: w_new = bus.csr_wdata;
            OP_SET:   w_new = w_old | bus.csr_wdata;
            OP_CLEAR: w_new = w_old & ~bus.csr_wdata;
            default:  w_new = w_old;
        endcase
    end

    assign bus.csr_rdata = w_old;
    assign bus.csr_hit   = w_hit;
    assign w_start       = w_is_cmd && w_new[0];

    // START and config accesses are judged against the pre-edge state, so a done
    // pulse in the same cycle does not let a START slip in.
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_sel[h]       = w_access && (bus.hart_id_i == HART_W'(h));
            w_start_ok[h]  = w_sel[h] && w_start && (r_state[h] == S_IDLE);
            w_start_err[h] = w_sel[h] && w_start && (r_state[h] != S_IDLE);
            w_cfg_err[h]   = w_sel[h] && (w_off < CMD_OFF) && (r_state[h] != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (rst) r_state[h] <= S_IDLE;
            else     r_state[h] <= w_state_nxt[h];
        end
    end

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_state_nxt[h] = r_state[h];
            case (r_state[h])
                S_IDLE:  if (w_start_ok[h]) w_state_nxt[h] = S_PEND;
                S_PEND:  if (w_grant && r_job_hart == HART_W'(h)) w_state_nxt[h] = S_RUN;
                S_RUN:   if (bus.mvu_done_i[h]) w_state_nxt[h] = S_IDLE;
                default: w_state_nxt[h] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pend          = '0;
        bus.busy_o      = '0;
        bus.dbg_state_o = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_pend[h]                = (r_state[h] == S_PEND);
            bus.busy_o[h]            = (r_state[h] != S_IDLE);
            bus.dbg_state_o[2*h +: 2] = r_state[h];
        end
    end

    assign bus.mvu_irq_o = r_done & r_irq_en;

    // Hardware-set DONE/ERR events win over a same-cycle software clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                for (int i = 0; i < NUM_CFG; i++) r_cfg[h][i] <= '0;
            end
            r_irq_en <= '0;
            r_done   <= '0;
            r_err    <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_sel[h]) begin
                    for (int i = 0; i < NUM_CFG; i++) begin
                        if (w_off == 12'(i) && r_state[h] == S_IDLE) r_cfg[h][i] <= w_new;
                    end
                    if (w_is_cmd) r_irq_en[h] <= w_new[1];
                end
                if (r_state[h] == S_RUN && bus.mvu_done_i[h])
                    r_done[h] <= 1'b1;
                else if (w_sel[h] && w_is_stat && bus.csr_op != OP_SET)
                    r_done[h] <= r_done[h] & w_new[2];
                if (w_start_err[h] || w_cfg_err[h])
                    r_err[h] <= 1'b1;
                else if (w_sel[h] && w_is_stat && bus.csr_op != OP_SET)
                    r_err[h] <= r_err[h] & w_new[3];
            end
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            if (!w_found && w_pend[HART_W'((int'(r_rr) + k) % NUM_HARTS)]) begin
                w_found = 1'b1;
                w_pick  = HART_W'((int'(r_rr) + k) % NUM_HARTS);
            end
        end
    end

    // The offered hart sits in PEND, where its config is write-protected, so job_cfg_o
    // can be read straight from the bank and still hold stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_job_valid <= 1'b0;
            r_job_hart  <= '0;
            r_rr        <= '0;
        end else if (w_grant) begin
            r_job_valid <= 1'b0;
            r_rr        <= HART_W'((int'(r_job_hart) + 1) % NUM_HARTS);
        end else if (!r_job_valid && w_found) begin
            r_job_valid <= 1'b1;
            r_job_hart  <= w_pick;
        end
    end

    always_comb begin
        bus.job_cfg_o = '0;
        for (int i = 0; i < NUM_CFG; i++) bus.job_cfg_o[32*i +: 32] = r_cfg[r_job_hart][i];
    end

    assign bus.job_valid_o = r_job_valid;
    assign bus.job_hart_o  = r_job_hart;
endmodule
